// File: rtl/eprom_prog_engine.sv
`default_nettype none
// ============================================================================
//  Module   : eprom_prog_engine
//  Purpose  : Parametrised EPROM programming sequencer. Runs fixed P-pulses,
//             closed-loop program/verify with retry limit and overprogram
//             pulse, and timed reads on a parallel-EPROM ZIF mapping.
//  Revision : 1.0  initial release
// ============================================================================
module eprom_prog_engine #(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 8,
    parameter int CLK_PER_UNIT  = 2400,
    parameter int SETUP_CYC     = 24,
    parameter int MAX_RETRY     = 25,
    parameter int OVERPROG_MULT = 3
) (
    input  logic              osc,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [1:0]        cmd,
    input  logic [7:0]        pulselen,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        retry_cnt,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dut_addr,
    output logic [DATA_W-1:0] dut_dout,
    output logic              dut_doe,
    input  logic [DATA_W-1:0] dut_din,
    output logic              dut_E,
    output logic              dut_G,
    output logic              dut_P
);

    localparam logic [1:0] CMD_NOP    = 2'd0;
    localparam logic [1:0] CMD_PPULSE = 2'd1;
    localparam logic [1:0] CMD_PV     = 2'd2;
    localparam logic [1:0] CMD_READ   = 2'd3;

    // Counter must cover the longest overprogram pulse.
    localparam int              OP_M    = (OVERPROG_MULT > 0) ? OVERPROG_MULT : 1;
    localparam longint unsigned MAX_CNT = 64'(255) * 64'(MAX_RETRY) * 64'(OP_M)
                                        * 64'(CLK_PER_UNIT) + 64'(SETUP_CYC);
    localparam int              CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_PULSE    = 3'd2,
        S_RECOVER  = 3'd3,
        S_VSETUP   = 3'd4,
        S_OVERPROG = 3'd5,
        S_RSETUP   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t            state_q;
    logic [1:0]        cmd_q;
    logic [7:0]        len_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_pulse_q;
    logic              busy_q, done_q, fail_q;
    logic [7:0]        retry_q;
    logic [DATA_W-1:0] rdata_q;
    logic              doe_q, e_q, g_q, p_q;

    // Counter reload values (terminal count = load + 1 cycles).
    logic [CNT_W-1:0]  setup_ld, pulse_ld, op_ld;
    assign setup_ld = CNT_W'(SETUP_CYC - 1);
    assign pulse_ld = CNT_W'(len_q) * CNT_W'(CLK_PER_UNIT) - CNT_W'(1);
    assign op_ld    = CNT_W'(OP_M) * CNT_W'(retry_q) * CNT_W'(len_q)
                    * CNT_W'(CLK_PER_UNIT) - CNT_W'(1);

    // Sequencer: state, timing counter and all registered pin/status outputs.
    always_ff @(posedge osc) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_NOP;
            len_q      <= 8'd1;
            data_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            op_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            retry_q    <= 8'd0;
            rdata_q    <= '0;
            doe_q      <= 1'b0;
            e_q        <= 1'b1;
            g_q        <= 1'b1;
            p_q        <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start && cmd != CMD_NOP) begin
                        cmd_q  <= cmd;
                        addr_q <= addr_in;
                        data_q <= wdata;
                        len_q  <= (pulselen == 8'd0) ? 8'd1 : pulselen;
                        busy_q <= 1'b1;
                        e_q    <= 1'b0;
                        cnt_q  <= setup_ld;
                        if (cmd == CMD_READ) begin
                            g_q     <= 1'b0;
                            state_q <= S_RSETUP;
                        end else begin
                            doe_q   <= 1'b1;
                            state_q <= S_SETUP;
                            if (cmd == CMD_PV) begin
                                fail_q  <= 1'b0;
                                retry_q <= 8'd0;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    // Re-entry from verify starts with the bus released for one cycle.
                    doe_q <= 1'b1;
                    if (cnt_q == '0) begin
                        p_q     <= 1'b0;
                        cnt_q   <= pulse_ld;
                        state_q <= S_PULSE;
                        if (cmd_q == CMD_PV) retry_q <= retry_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        p_q     <= 1'b1;
                        cnt_q   <= setup_ld;
                        state_q <= S_RECOVER;
                        if (cmd_q == CMD_PV && SETUP_CYC == 1) doe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    if (cnt_q == '0) begin
                        if (cmd_q == CMD_PV) begin
                            doe_q   <= 1'b0;
                            g_q     <= 1'b0;
                            cnt_q   <= setup_ld;
                            state_q <= S_VSETUP;
                        end else begin
                            done_q  <= 1'b1;
                            e_q     <= 1'b1;
                            g_q     <= 1'b1;
                            doe_q   <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end else begin
                        // Release data one cycle before the DUT turns the bus around.
                        if (cmd_q == CMD_PV && cnt_q == CNT_W'(1)) doe_q <= 1'b0;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_VSETUP: begin
                    if (cnt_q == '0) begin
                        rdata_q <= dut_din;
                        g_q     <= 1'b1;
                        cnt_q   <= setup_ld;
                        if (dut_din == data_q) begin
                            if (OVERPROG_MULT > 0) begin
                                op_pulse_q <= 1'b0;
                                state_q    <= S_OVERPROG;
                            end else begin
                                done_q  <= 1'b1;
                                e_q     <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else if (retry_q < 8'(MAX_RETRY)) begin
                            state_q <= S_SETUP;
                        end else begin
                            fail_q  <= 1'b1;
                            done_q  <= 1'b1;
                            e_q     <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_OVERPROG: begin
                    if (!op_pulse_q) begin
                        doe_q <= 1'b1;
                        if (cnt_q == '0) begin
                            p_q        <= 1'b0;
                            op_pulse_q <= 1'b1;
                            cnt_q      <= op_ld;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end else if (cnt_q == '0) begin
                        p_q     <= 1'b1;
                        done_q  <= 1'b1;
                        e_q     <= 1'b1;
                        g_q     <= 1'b1;
                        doe_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RSETUP: begin
                    if (cnt_q == '0) begin
                        rdata_q <= dut_din;
                        done_q  <= 1'b1;
                        e_q     <= 1'b1;
                        g_q     <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign rdata     = rdata_q;
    assign dut_addr  = addr_q;
    assign dut_dout  = data_q;
    assign dut_doe   = doe_q;
    assign dut_E     = e_q;
    assign dut_G     = g_q;
    assign dut_P     = p_q;

endmodule
`default_nettype wire

// File: doc/eprom_prog_engine.md
Name: eprom_prog_engine

Overview:
- Parametrised successor to the fixed 2764-class P-pulse sequencer: one synchronous engine drives any parallel-EPROM ZIF mapping.
- Generalised address and data width.
- Adds a closed-loop program/verify ("intelligent") algorithm with retry limit and overprogram pulse, plus a timed read command.
- Sits between the bus register decoder (command/operand latches) and the per-chip ZIF pin mapping.

Parameters:
ADDR_W, 13, DUT address width
DATA_W, 8, DUT data width
CLK_PER_UNIT, 2400, osc cycles per pulse unit (100 us at 24 MHz)
SETUP_CYC, 24, osc cycles for address/data setup, recovery and read access
MAX_RETRY, 25, maximum program pulses per location in PROG_VERIFY (>=1)
OVERPROG_MULT, 3, overprogram multiplier; 0 disables the overprogram pulse

Ports:
osc  in  1  24 MHz clock
rst  in  1  synchronous active-high reset
cmd_start  in  1  one-cycle command strobe
cmd  in  2  0=NOP, 1=PPULSE, 2=PROG_VERIFY, 3=READ
pulselen  in  8  pulse length in units; 0 is treated as 1
addr_in  in  ADDR_W  target address
wdata  in  DATA_W  data to program
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
fail  out  1  last PROG_VERIFY exhausted MAX_RETRY
retry_cnt  out  8  pulses used by last PROG_VERIFY
rdata  out  DATA_W  last sampled DUT data
dut_addr  out  ADDR_W  DUT address
dut_dout  out  DATA_W  data driven to DUT
dut_doe  out  1  1 = FPGA drives DUT data pins
dut_din  in  DATA_W  DUT data pins (read path)
dut_E, dut_G, dut_P  out  1 each  chip enable, output enable, program strobe; all active low

Behaviour:
- Reset values: busy=0, done=0, fail=0, retry_cnt=0, rdata=0, dut_addr=0, dut_dout=0, dut_doe=0, dut_E=1, dut_G=1, dut_P=1, state=IDLE.
- Reset takes effect at the next edge from any state, including mid-pulse; dut_P returns high at that edge.
- States: IDLE, SETUP, PULSE, RECOVER, VSETUP, OVERPROG, RSETUP, DONE.
- IDLE:
  - cmd_start with cmd 1–3: latch addr_in, wdata and max(pulselen,1). busy=1 from the next cycle.
  - cmd=0 or no strobe: no action.
  - cmd_start while busy is ignored; operands are not relatched.
- PPULSE / PROG_VERIFY:
  - PROG_VERIFY start clears fail and retry_cnt.
  - SETUP: dut_E=0, dut_G=1, dut_doe=1, dut_dout=data; hold SETUP_CYC cycles.
  - PULSE: dut_P=0 for exactly len*CLK_PER_UNIT cycles; retry_cnt increments on entry (PROG_VERIFY only).
  - RECOVER: dut_P=1, held SETUP_CYC cycles.
  - PPULSE: RECOVER -> DONE.
- PROG_VERIFY verify loop:
  - RECOVER -> VSETUP: dut_doe=0, dut_G=0 for SETUP_CYC cycles.
  - Last VSETUP cycle: sample dut_din into rdata.
  - rdata==data and OVERPROG_MULT>0: go to OVERPROG.
  - rdata==data and OVERPROG_MULT==0: go to DONE.
  - Mismatch and retry_cnt<MAX_RETRY: dut_G=1, back to SETUP.
  - Mismatch and retry_cnt==MAX_RETRY: fail=1, go to DONE.
- OVERPROG:
  - Drive data again (dut_G=1, dut_doe=1) for SETUP_CYC cycles.
  - Then dut_P=0 for OVERPROG_MULT*retry_cnt*len*CLK_PER_UNIT cycles, then dut_P=1.
  - Then go to DONE. The counter must be wide enough for 255*MAX_RETRY*OVERPROG_MULT units.
- READ:
  - RSETUP: dut_E=0, dut_G=0, dut_doe=0 for SETUP_CYC cycles.
  - rdata captured on the last cycle; go to DONE.
- DONE (one cycle): done=1, dut_E=1, dut_G=1, dut_P=1, dut_doe=0. busy=0 from the following cycle; return to IDLE.
- Bus contention rule: dut_doe and !dut_G are never both 1 in the same cycle. A cycle with dut_doe=0 and dut_G=1 separates every direction change.
- fail, retry_cnt and rdata hold until the next command that updates them.
- dut_addr holds after completion.

Test Plan:
1. Test parameters: CLK_PER_UNIT=4, SETUP_CYC=2, MAX_RETRY=3, OVERPROG_MULT=3. PPULSE with pulselen=5, addr=0x1ABC, wdata=0x5A -> dut_P low for exactly 20 cycles; dut_addr=0x1ABC and dut_dout=0x5A throughout; done asserted once; busy for 2+20+2+1 cycles.
2. PROG_VERIFY with pulselen=1; dut_din model returns 0xFF on the first verify and wdata=0x3C on the second -> two 4-cycle pulses; retry_cnt=2; overprogram pulse of 24 cycles; fail=0; rdata=0x3C.
3. PROG_VERIFY with dut_din stuck at 0xFF, wdata=0x00 -> exactly 3 pulses; no overprogram pulse; fail=1; retry_cnt=3; done pulses once.
4. READ at addr=0x0007 with dut_din=0xA5 -> dut_E=0 and dut_G=0 for 2 cycles; dut_P stays 1 throughout; rdata=0xA5; done asserted.
5. pulselen=0 PPULSE -> 4-cycle pulse. cmd_start during busy -> ignored, latched operands unchanged. cmd=0 -> busy never asserts.
6. rst asserted on the 10th cycle of a PPULSE pulse -> next cycle: dut_P=1, busy=0, dut_E=1, dut_G=1, dut_doe=0. A new PPULSE afterwards completes normally. A checker asserts the contention rule across all tests.
